cmp_seq_n: RTL and testbench
============================

Name: cmp_seq_n

Overview:
Parametrised, multi-cycle magnitude comparator. It is the clocked successor to the 4-bit gate-level comparator family. It compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, stops early at the first differing digit, and supports signed or unsigned mode. A start/busy/done handshake connects it to lab control FSMs; the _EQL/_GT/_LT result flags are registered and held.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits compared per clock; 1 <= DIGIT <= WIDTH.
NDIG (localparam), WIDTH/DIGIT, number of digits.
CW (localparam), clog2(NDIG+1), width of the digit-count output.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a comparison; accepted only when busy==0.
SIGNED  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
A  input  WIDTH  operand A; sampled with start.
B  input  WIDTH  operand B; sampled with start.
busy  output  1  comparison in progress.
done  output  1  one-cycle pulse when results become valid.
_EQL  output  1  A == B.
_GT  output  1  A > B.
_LT  output  1  A < B.
digits  output  CW  number of digits examined for the last result (1..NDIG).

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst is high: state=IDLE; busy, done, _EQL, _GT, _LT = 0; digits = 0; internal registers cleared. Reset aborts any comparison in flight, and no done pulse follows.
- States: IDLE, RUN, DONE.
- Accept: on a rising edge with start=1 and busy=0 (state IDLE or DONE):
  - latch A, B and SIGNED into internal registers;
  - set digit index idx = NDIG-1;
  - clear _EQL/_GT/_LT and digits;
  - go to RUN; busy=1 from the next cycle.
- Ignored start: start while busy=1 has no effect. Operand changes during RUN have no effect.
- Each RUN cycle compares digit idx of the latched A and B (bits idx*DIGIT+DIGIT-1 down to idx*DIGIT).
  - Signed mode, top digit only: invert the MSB of both digits before comparing. This biases the sign bit, so no subtraction is needed.
- RUN exit conditions, evaluated at the rising edge ending the cycle:
  - Digits differ: set _GT or _LT, set digits = NDIG-idx, go to DONE.
  - Digits equal and idx==0: set _EQL=1, set digits = NDIG, go to DONE.
  - Digits equal and idx>0: decrement idx, stay in RUN.
- DONE: lasts exactly one cycle. busy=0, done=1, then return to IDLE. A start sampled in DONE is accepted, which allows back-to-back operations.
- Result holding: _EQL/_GT/_LT/digits stay stable after done until the next accepted start.
- One-hot results: exactly one of _EQL/_GT/_LT is 1 in every cycle after the first done and before the next accept.
- Latency: the accept edge is E0 and result edge is Ek, where k = digits examined (1..NDIG). Minimum latency 1 cycle, maximum NDIG. Throughput is one compare per k+1 cycles.
- NDIG==1: the whole operand is compared in one RUN cycle; the idx register may be optimised away.
- Counters: idx and digits must never wrap; idx is not decremented past 0.

Decomposition:
- Shared include file cmp_defs.v holds:
  - state encodings CMP_IDLE, CMP_RUN, CMP_DONE;
  - the clog2 helper function.
- Sub-module cmp_digit: purely combinational, parameter DIGIT.
  - Inputs a, b, flip_msb.
  - Outputs eq, gt, lt.
  - Written as a ripple of 1-bit compare cells: (A==B) is the AND of per-bit equalities; GT/LT is an OR of prefix-equality products.
- cmp_seq_n: FSM, operand registers, idx and digits counters, result registers.

Test Plan:
1. WIDTH=16, DIGIT=4, unsigned, A=0x1234, B=0x1234 -> _EQL=1, _GT=_LT=0, digits=4, done 4 cycles after accept, busy high for 4 cycles.
2. Unsigned, A=0x9000, B=0x1000 -> _GT=1, digits=1, done 1 cycle after accept.
3. Signed, A=0x9000, B=0x1000 -> _LT=1 (-28672 < 4096), digits=1.
4. Unsigned, A=0x12A4, B=0x12B4 -> _LT=1, digits=3. Then start pulsed again during RUN with A=B=0 -> ignored; results unchanged.
5. Start A=B=0xFFFF, then assert rst two cycles after accept -> all outputs 0 immediately, no done. After rst is released, start A=0x0001, B=0x0000 -> _GT=1, digits=4.
6. Configs WIDTH=4/DIGIT=1 and WIDTH=8/DIGIT=8, exhaustive operand pairs in both modes, back-to-back starts issued in DONE -> flags match the integer compare model; digits equals the index of the first differing digit +1, or NDIG when A==B.

Source files
------------

// File: rtl/cmp_seq_n_pkg.sv
// Shared definitions for the multi-cycle magnitude comparator: FSM state
// encodings and a constant-safe ceiling-log2 helper.
package cmp_seq_n_pkg;

    typedef enum logic [1:0] {
        CMP_IDLE = 2'd0,
        CMP_RUN  = 2'd1,
        CMP_DONE = 2'd2
    } cmp_state_t;

    // Ceiling log2; usable in localparam expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmp_seq_n_if.sv
// Request/result bundle between a control FSM (master) and the sequential
// comparator (slave).
interface cmp_seq_n_if #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
);
    import cmp_seq_n_pkg::*;

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = clog2(NDIG + 1);

    // Handshake: the master raises start with SIGNED/A/B valid; the request is
    // taken on the first rising edge where busy==0 (start while busy is dropped).
    // busy is high for every RUN cycle, done pulses for exactly one cycle when
    // _EQL/_GT/_LT/digits become valid, and those stay held until the next accept.
    logic             start;
    logic             SIGNED;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             _EQL;
    logic             _GT;
    logic             _LT;
    logic [CW-1:0]    digits;

    modport master (
        output start, SIGNED, A, B,
        input  busy, done, _EQL, _GT, _LT, digits
    );

    modport slave (
        input  start, SIGNED, A, B,
        output busy, done, _EQL, _GT, _LT, digits
    );

endinterface

// File: rtl/cmp_seq_n_digit.sv
// Combinational DIGIT-bit magnitude compare built as a ripple of 1-bit cells,
// with an optional MSB inversion used to bias the sign bit in signed mode.
module cmp_seq_n_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             flip_msb,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    logic [DIGIT-1:0] aa;
    logic [DIGIT-1:0] bb;
    logic [DIGIT:0]   pre_eq;

    always_comb begin
        aa = a;
        bb = b;
        aa[DIGIT-1] = a[DIGIT-1] ^ flip_msb;
        bb[DIGIT-1] = b[DIGIT-1] ^ flip_msb;
        gt = 1'b0;
        lt = 1'b0;
        pre_eq = '0;
        pre_eq[DIGIT] = 1'b1;
        // pre_eq[i+1] means every bit above i matched, so bit i decides.
        for (int i = DIGIT - 1; i >= 0; i--) begin
            gt = gt | (pre_eq[i+1] &  aa[i] & ~bb[i]);
            lt = lt | (pre_eq[i+1] & ~aa[i] &  bb[i]);
            pre_eq[i] = pre_eq[i+1] & ~(aa[i] ^ bb[i]);
        end
        eq = pre_eq[0];
    end

endmodule

// File: rtl/cmp_seq_n.sv
// Multi-cycle MSB-first magnitude comparator: DIGIT bits per clock, early exit
// on the first differing digit, signed or unsigned, registered held results.
module cmp_seq_n
    import cmp_seq_n_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    cmp_seq_n_if.slave bus,
    output cmp_state_t dbg_state
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = clog2(NDIG + 1);
    localparam int IW   = (NDIG > 1) ? clog2(NDIG) : 1;

    localparam logic [IW-1:0] IDX_TOP = IW'(NDIG - 1);
    localparam logic [CW-1:0] NDIG_CW = CW'(NDIG);

    cmp_state_t       state_q, state_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic             sgn_q, sgn_n;
    logic [IW-1:0]    idx_q, idx_n;
    logic             eql_q, eql_n;
    logic             gt_q, gt_n;
    logic             lt_q, lt_n;
    logic [CW-1:0]    digits_q, digits_n;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic             flip;
    logic             d_eq;
    logic             d_gt;
    logic             d_lt;

    assign a_dig = a_q[int'(idx_q) * DIGIT +: DIGIT];
    assign b_dig = b_q[int'(idx_q) * DIGIT +: DIGIT];
    // Only the top digit carries the sign bit.
    assign flip  = sgn_q & (idx_q == IDX_TOP);

    cmp_seq_n_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a        (a_dig),
        .b        (b_dig),
        .flip_msb (flip),
        .eq       (d_eq),
        .gt       (d_gt),
        .lt       (d_lt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CMP_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            idx_q    <= '0;
            eql_q    <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            digits_q <= '0;
        end else begin
            state_q  <= state_n;
            a_q      <= a_n;
            b_q      <= b_n;
            sgn_q    <= sgn_n;
            idx_q    <= idx_n;
            eql_q    <= eql_n;
            gt_q     <= gt_n;
            lt_q     <= lt_n;
            digits_q <= digits_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        a_n      = a_q;
        b_n      = b_q;
        sgn_n    = sgn_q;
        idx_n    = idx_q;
        eql_n    = eql_q;
        gt_n     = gt_q;
        lt_n     = lt_q;
        digits_n = digits_q;
        case (state_q)
            CMP_IDLE, CMP_DONE: begin
                if (bus.start) begin
                    a_n      = bus.A;
                    b_n      = bus.B;
                    sgn_n    = bus.SIGNED;
                    idx_n    = IDX_TOP;
                    eql_n    = 1'b0;
                    gt_n     = 1'b0;
                    lt_n     = 1'b0;
                    digits_n = '0;
                    state_n  = CMP_RUN;
                end else begin
                    state_n  = CMP_IDLE;
                end
            end
            CMP_RUN: begin
                if (!d_eq) begin
                    gt_n     = d_gt;
                    lt_n     = d_lt;
                    digits_n = NDIG_CW - CW'(idx_q);
                    state_n  = CMP_DONE;
                end else if (idx_q == '0) begin
                    eql_n    = 1'b1;
                    digits_n = NDIG_CW;
                    state_n  = CMP_DONE;
                end else begin
                    idx_n    = idx_q - IW'(1);
                end
            end
            default: state_n = CMP_IDLE;
        endcase
    end

    assign bus.busy   = (state_q == CMP_RUN);
    assign bus.done   = (state_q == CMP_DONE);
    assign bus._EQL   = eql_q;
    assign bus._GT    = gt_q;
    assign bus._LT    = lt_q;
    assign bus.digits = digits_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cmp_seq_n.sv
// Directed and swept checks of cmp_seq_n in three width/digit configurations.
module tb_cmp_seq_n;
    import cmp_seq_n_pkg::*;

    localparam int BUDGET = 24;

    logic clk;
    logic rst;

    cmp_seq_n_if #(.WIDTH(16), .DIGIT(4)) i16 ();
    cmp_seq_n_if #(.WIDTH(4),  .DIGIT(1)) i4  ();
    cmp_seq_n_if #(.WIDTH(8),  .DIGIT(8)) i8  ();

    cmp_state_t st16, st4, st8;

    cmp_seq_n #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .rst(rst), .bus(i16), .dbg_state(st16));
    cmp_seq_n #(.WIDTH(4),  .DIGIT(1)) u4  (.clk(clk), .rst(rst), .bus(i4),  .dbg_state(st4));
    cmp_seq_n #(.WIDTH(8),  .DIGIT(8)) u8  (.clk(clk), .rst(rst), .bus(i8),  .dbg_state(st8));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // packed result {eql, gt, lt, digits[4:0]}
    function automatic logic [7:0] pk(input logic e, input logic g, input logic l, input int d);
        return {e, g, l, 5'(d)};
    endfunction

    function automatic logic [7:0] res16();
        return {i16._EQL, i16._GT, i16._LT, 5'(i16.digits)};
    endfunction

    function automatic logic [7:0] res4();
        return {i4._EQL, i4._GT, i4._LT, 5'(i4.digits)};
    endfunction

    function automatic logic [7:0] res8();
        return {i8._EQL, i8._GT, i8._LT, 5'(i8.digits)};
    endfunction

    // reference model: integer compare plus first differing digit from the top
    function automatic int sx(input int v, input int w, input logic sgn);
        if (sgn && v[w-1]) return v - (1 << w);
        return v;
    endfunction

    function automatic logic [7:0] model(input int a, input int b, input int w,
                                         input int dg, input logic sgn);
        int ia, ib, nd, d;
        ia = sx(a, w, sgn);
        ib = sx(b, w, sgn);
        nd = w / dg;
        d = nd;
        for (int j = 0; j < nd; j++) begin
            if ((((a >> (j * dg)) ^ (b >> (j * dg))) & ((1 << dg) - 1)) != 0) d = nd - j;
        end
        return pk(ia == ib, ia > ib, ia < ib, d);
    endfunction

    // driver tasks: entered at a negedge in IDLE or DONE; leave at the negedge where done is seen
    task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                        input logic poke, output logic [7:0] res, output int lat,
                        output int busy_n);
        i16.start = 1'b1; i16.A = a; i16.B = b; i16.SIGNED = sgn;
        @(negedge clk);
        i16.start = 1'b0;
        lat = 0;
        busy_n = 0;
        while (!i16.done && lat < BUDGET) begin
            if (i16.busy) busy_n++;
            if (poke && lat == 0) begin
                i16.start = 1'b1; i16.A = '0; i16.B = '0; i16.SIGNED = 1'b0;
            end else begin
                i16.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        i16.start = 1'b0;
        res = res16();
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic sgn,
                       output logic [7:0] res, output int lat);
        i4.start = 1'b1; i4.A = a; i4.B = b; i4.SIGNED = sgn;
        @(negedge clk);
        i4.start = 1'b0;
        lat = 0;
        while (!i4.done && lat < BUDGET) begin
            @(negedge clk);
            lat++;
        end
        res = res4();
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                       output logic [7:0] res, output int lat);
        i8.start = 1'b1; i8.A = a; i8.B = b; i8.SIGNED = sgn;
        @(negedge clk);
        i8.start = 1'b0;
        lat = 0;
        while (!i8.done && lat < BUDGET) begin
            @(negedge clk);
            lat++;
        end
        res = res8();
    endtask

    initial begin
        logic [7:0] res;
        logic [7:0] exp;
        logic [7:0] bl[12];
        int lat;
        int bn;
        int done_cnt;

        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        i16.start = 1'b0; i16.SIGNED = 1'b0; i16.A = '0; i16.B = '0;
        i4.start  = 1'b0; i4.SIGNED  = 1'b0; i4.A  = '0; i4.B  = '0;
        i8.start  = 1'b0; i8.SIGNED  = 1'b0; i8.A  = '0; i8.B  = '0;
        repeat (2) @(negedge clk);

        check("rst16_ctl",   {i16.busy, i16.done}, 2'b00);
        check("rst16_res",   res16(), 8'h00);
        check("rst16_state", st16, CMP_IDLE);
        check("rst4_res",    {i4.busy, i4.done, res4()}, 10'h000);
        check("rst8_res",    {i8.busy, i8.done, res8()}, 10'h000);
        rst = 1'b0;
        @(negedge clk);

        // equal operands walk all four digits
        go16(16'h1234, 16'h1234, 1'b0, 1'b0, res, lat, bn);
        check("t1_res",  res, pk(1, 0, 0, 4));
        check("t1_lat",  lat, 4);
        check("t1_busy", bn, 4);
        @(negedge clk);
        check("t1_done_pulse", {i16.done, i16.busy}, 2'b00);
        check("t1_hold", res16(), pk(1, 0, 0, 4));

        // early exit on the top digit, then the same operands signed back-to-back
        go16(16'h9000, 16'h1000, 1'b0, 1'b0, res, lat, bn);
        check("t2_res", res, pk(0, 1, 0, 1));
        check("t2_lat", lat, 1);
        go16(16'h9000, 16'h1000, 1'b1, 1'b0, res, lat, bn);
        check("t3_res", res, pk(0, 0, 1, 1));
        check("t3_lat", lat, 1);

        // third digit differs; a start pulsed during RUN must be ignored
        go16(16'h12A4, 16'h12B4, 1'b0, 1'b1, res, lat, bn);
        check("t4_res", res, pk(0, 0, 1, 3));
        check("t4_lat", lat, 3);
        repeat (3) @(negedge clk);
        check("t4_hold",  res16(), pk(0, 0, 1, 3));
        check("t4_idle",  {i16.busy, i16.done}, 2'b00);
        check("t4_state", st16, CMP_IDLE);

        // reset in mid-flight clears everything and suppresses done
        i16.start = 1'b1; i16.A = 16'hFFFF; i16.B = 16'hFFFF; i16.SIGNED = 1'b0;
        @(negedge clk);
        i16.start = 1'b0;
        @(negedge clk);
        check("t5_pre_busy", i16.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_rst_ctl",   {i16.busy, i16.done}, 2'b00);
        check("t5_rst_res",   res16(), 8'h00);
        check("t5_rst_state", st16, CMP_IDLE);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (i16.done) done_cnt++;
        end
        check("t5_no_done", done_cnt, 0);
        go16(16'h0001, 16'h0000, 1'b0, 1'b0, res, lat, bn);
        check("t5_res", res, pk(0, 1, 0, 4));
        check("t5_lat", lat, 4);

        // WIDTH=4 DIGIT=1: all pairs, both modes, starts issued in DONE
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    exp_q.push_back(model(a, b, 4, 1, s[0]));
                    go4(4'(a), 4'(b), s[0], res, lat);
                    exp = exp_q.pop_front();
                    check("w4_res", res, exp);
                    check("w4_lat", lat, int'(exp[4:0]));
                end
            end
        end

        // WIDTH=8 DIGIT=8: every A against boundary and A-relative B values
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 256; a++) begin
                bl = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h55, 8'hAA,
                       8'(a), 8'(a) ^ 8'h01, 8'(a) ^ 8'h80};
                for (int k = 0; k < 12; k++) begin
                    exp_q.push_back(model(a, int'(bl[k]), 8, 8, s[0]));
                    go8(8'(a), bl[k], s[0], res, lat);
                    exp = exp_q.pop_front();
                    check("w8_res", res, exp);
                    check("w8_lat", lat, 1);
                end
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
